// File: rtl/bcd_job_timer.sv
// Times a job in BCD ticks from release of job_rst_n until job_done.
// One-hot control FSM; time_ascii is a direct digit-wise view of time_bcd.
module bcd_job_timer #(
    parameter int DIGITS      = 8,
    parameter int TICK_CYCLES = 1,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  job_done,
    output logic                  job_rst_n,
    output logic                  busy,
    output logic                  valid,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [8*DIGITS-1:0]   time_ascii
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CLR  = 4'b0010,
        RUN  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [W-1:0]  bcd_inc;
    logic          carry;
    logic          tick;

    // abort always wins over start and job_done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = abort ? IDLE : (start ? CLR : IDLE);
            CLR:     state_nxt = abort ? IDLE : RUN;
            RUN:     state_nxt = abort ? IDLE : (job_done ? DONE : RUN);
            DONE:    state_nxt = abort ? IDLE : (start ? CLR : DONE);
            default: state_nxt = IDLE;
        endcase
    end

    // carry is left high only when every digit was 9
    always_comb begin
        bcd_inc = time_bcd;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (time_bcd[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = time_bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    assign tick = (state == RUN) && (presc == PMAX) && !job_done && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            job_rst_n <= 1'b0;
            overflow  <= 1'b0;
            time_bcd  <= '0;
            presc     <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt == CLR) || (state_nxt == RUN);
            valid     <= (state_nxt == DONE);
            job_rst_n <= (state_nxt == RUN) || (state_nxt == DONE);
            if (state == CLR) begin
                time_bcd <= '0;
                presc    <= '0;
                overflow <= 1'b0;
            end else if (state == RUN) begin
                presc <= (presc == PMAX) ? '0 : presc + PW'(1);
                if (tick) begin
                    if (carry) begin
                        overflow <= 1'b1;
                        if (!SATURATE) time_bcd <= bcd_inc;
                    end else begin
                        time_bcd <= bcd_inc;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_ascii
        assign time_ascii[8*g +: 8] = {4'h3, time_bcd[4*g +: 4]};
    end

endmodule

// File: tb/tb_bcd_job_timer.sv
// Directed bench for bcd_job_timer across four parameter sets sharing stimulus.
module tb_bcd_job_timer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic job_done = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic        j8, b8, v8, o8;
    logic [31:0] t8;
    logic [63:0] a8;
    logic        j10, b10, v10, o10;
    logic [31:0] t10;
    logic [63:0] a10;
    logic        js, bs, vs, os;
    logic [7:0]  ts;
    logic [15:0] as_;
    logic        jw, bw, vw, ow;
    logic [7:0]  tw;
    logic [15:0] aw;

    bcd_job_timer #(.DIGITS(8), .TICK_CYCLES(1), .SATURATE(1'b1)) u8 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .job_done(job_done), .job_rst_n(j8), .busy(b8), .valid(v8),
        .overflow(o8), .time_bcd(t8), .time_ascii(a8));

    bcd_job_timer #(.DIGITS(8), .TICK_CYCLES(10), .SATURATE(1'b1)) u10 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .job_done(job_done), .job_rst_n(j10), .busy(b10), .valid(v10),
        .overflow(o10), .time_bcd(t10), .time_ascii(a10));

    bcd_job_timer #(.DIGITS(2), .TICK_CYCLES(1), .SATURATE(1'b1)) u2s (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .job_done(job_done), .job_rst_n(js), .busy(bs), .valid(vs),
        .overflow(os), .time_bcd(ts), .time_ascii(as_));

    bcd_job_timer #(.DIGITS(2), .TICK_CYCLES(1), .SATURATE(1'b0)) u2w (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .job_done(job_done), .job_rst_n(jw), .busy(bw), .valid(vw),
        .overflow(ow), .time_bcd(tw), .time_ascii(aw));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // start pulse, then job_done in cycle t0+n; returns at a negedge in DONE
    task automatic run(input int n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (n + 1) @(negedge clk);
        job_done = 1'b1;
        @(negedge clk) job_done = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_busy", b8, 1'b0);
        chk("rst_valid", v8, 1'b0);
        chk("rst_jrst", j8, 1'b0);
        chk("rst_ovf", o8, 1'b0);
        chk("rst_time", t8, 32'h0);
        chk("rst_ascii", a8, 64'h3030303030303030);

        @(negedge clk) reset_n = 1'b1;
        job_done = 1'b1;
        @(negedge clk) job_done = 1'b0;
        @(negedge clk);
        chk("idle_jd_busy", b8, 1'b0);
        chk("idle_jd_valid", v8, 1'b0);

        run(37);
        chk("n37_valid", v8, 1'b1);
        chk("n37_time", t8, 32'h00000037);
        chk("n37_ascii", a8, 64'h3030303030303337);
        chk("n37_ovf", o8, 1'b0);
        chk("n37_t10", t10, 32'h00000003);
        chk("n37_u2s", ts, 8'h37);
        chk("n37_u2s_ovf", os, 1'b0);
        chk("n37_u2w", tw, 8'h37);

        repeat (4) @(negedge clk);
        chk("hold_valid", v8, 1'b1);
        chk("hold_time", t8, 32'h00000037);
        chk("hold_jrst", j8, 1'b1);
        chk("hold_busy", b8, 1'b0);

        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("dabort_valid", v8, 1'b0);
        chk("dabort_jrst", j8, 1'b0);
        chk("dabort_time", t8, 32'h00000037);

        run(129);
        chk("n129_t10", t10, 32'h00000012);
        chk("n129_t8", t8, 32'h00000129);
        chk("n129_u2s", ts, 8'h99);
        chk("n129_u2s_ovf", os, 1'b1);
        chk("n129_u2w", tw, 8'h29);
        chk("n129_u2w_ovf", ow, 1'b1);

        run(9);
        chk("n9_t10", t10, 32'h00000000);
        chk("n9_t8", t8, 32'h00000009);
        chk("n9_u2s_ovf", os, 1'b0);
        run(10);
        chk("n10_t10", t10, 32'h00000001);
        chk("n10_t8", t8, 32'h00000010);

        run(150);
        chk("n150_u2s", ts, 8'h99);
        chk("n150_u2s_ovf", os, 1'b1);
        chk("n150_u2s_ascii", as_, 16'h3939);
        chk("n150_u2w", tw, 8'h50);
        chk("n150_u2w_ovf", ow, 1'b1);
        chk("n150_t8", t8, 32'h00000150);
        chk("n150_t10", t10, 32'h00000015);
        chk("n150_jrst", js, 1'b1);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("clr_jrst", js, 1'b0);
        chk("clr_busy", bs, 1'b1);
        chk("clr_valid", vs, 1'b0);
        @(negedge clk);
        chk("t0_jrst", js, 1'b1);
        chk("t0_time", ts, 8'h00);
        chk("t0_ovf", os, 1'b0);
        chk("t0_t8", t8, 32'h0);
        repeat (5) @(negedge clk);
        job_done = 1'b1;
        @(negedge clk) job_done = 1'b0;
        chk("rerun_valid", v8, 1'b1);
        chk("rerun_t8", t8, 32'h00000005);
        chk("rerun_t10", t10, 32'h00000000);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (21) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("ab_busy", b8, 1'b0);
        chk("ab_jrst", j8, 1'b0);
        chk("ab_valid", v8, 1'b0);
        chk("ab_t8", t8, 32'h00000020);
        chk("ab_t10", t10, 32'h00000002);
        job_done = 1'b1;
        @(negedge clk) job_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_jd_busy", b8, 1'b0);
        chk("ab_jd_valid", v8, 1'b0);
        chk("ab_jd_t8", t8, 32'h00000020);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (120) @(negedge clk);
        chk("pre_rst_ovf", os, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", b8, 1'b0);
        chk("arst_jrst", j8, 1'b0);
        chk("arst_t8", t8, 32'h0);
        chk("arst_ovf", os, 1'b0);
        chk("arst_u2s", ts, 8'h00);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", b8, 1'b0);
        chk("post_rst_jrst", j8, 1'b0);
        chk("post_rst_t8", t8, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
